ps2_key_event_fifo: RTL and testbench
=====================================

Name: ps2_key_event_fifo

Overview:
Parametrised PS/2 keyboard event front-end that sits between PS2_Interface and the processor/VGA logic. It replaces the single-byte ps2_key_data hand-off and the unused ps2_fsm debouncer. It decodes E0 (extended) and F0 (break) prefixes into complete key events and buffers them in a show-ahead FIFO. It also maintains a held-key bitmap for a configurable set of game keys, with optional typematic-repeat suppression.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
ADDR_W, 3, log2(DEPTH).
NUM_KEYS, 4, number of tracked keys in keys_held.
KEY_CODES, {9'h175,9'h172,9'h16B,9'h174}, NUM_KEYS packed 9-bit {ext,code} entries; entry i maps to keys_held[i]; default is up/down/left/right arrows.
SUPPRESS_REPEAT, 1, 1 = drop make events for keys already held in keys_held.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
ps2_key_pressed  in  1  byte-received strobe from PS2_Interface
ps2_key_data  in  8  received scan byte
rd_en  in  1  pop request
event_data  out  10  head event {brk, ext, code[7:0]}; valid only while event_valid=1
event_valid  out  1  FIFO not empty
event_count  out  ADDR_W+1  entries held, 0..DEPTH
overflow  out  1  sticky: an event was dropped because the FIFO was full
clear_overflow  in  1  clears overflow
keys_held  out  NUM_KEYS  1 = tracked key currently down

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: decoder state IDLE, rd_ptr=wr_ptr=0, event_count=0, event_valid=0, overflow=0, keys_held=0, edge register=0, event_data=mem[0] (don't-care). Reset in the middle of a prefix sequence discards the partial sequence. Reset has priority over all other inputs.
- Byte accept: a byte is accepted in a cycle when ps2_key_pressed=1 and the registered previous ps2_key_pressed=0. A strobe held high for multiple cycles therefore yields exactly one byte.
- Decoder FSM (states IDLE, E0, F0, E0F0), on each accepted byte:
  - IDLE: E0 -> E0; F0 -> F0; other -> emit {0,0,byte}, stay IDLE.
  - E0: F0 -> E0F0; E0 -> E0; other -> emit {0,1,byte}, go IDLE.
  - F0: E0 -> E0 (protocol error, restart); F0 -> F0; other -> emit {1,0,byte}, go IDLE.
  - E0F0: E0 -> E0; F0 -> E0F0; other -> emit {1,1,byte}, go IDLE.
  - Byte 00 or FF (keyboard error/overrun): no emit, go IDLE.
- Held-key map: on an emit whose {ext,code} matches KEY_CODES[i], keys_held[i] <= ~brk. This takes effect at the same edge as the FIFO write, and applies even if the event is dropped as a repeat or by a full FIFO.
- Repeat suppression: when SUPPRESS_REPEAT=1, a make event for a tracked key whose keys_held bit is already 1 is not written to the FIFO and does not set overflow. Untracked keys are never suppressed.
- Latency: the accepted final byte in cycle t is visible on event_valid/event_data after the edge ending cycle t (1 cycle).
- FIFO: show-ahead; event_data=mem[rd_ptr] is combinational from registered pointers. Pointers wrap modulo DEPTH.
  - Pop: when rd_en=1 and event_count>0, rd_ptr advances. rd_en when empty is ignored with no underflow.
  - Push: on emit. If event_count==DEPTH and no pop in the same cycle, the event is dropped and overflow<=1.
  - Simultaneous pop+push when full: both occur and event_count stays DEPTH.
  - Simultaneous pop+push when empty: push only and event_count becomes 1.
- overflow: clear_overflow=1 clears it, unless a drop occurs in the same cycle (set wins).
- event_count: registered; +1 on push only, -1 on pop only, unchanged on both or neither.

Test Plan:
1. Reset, then bytes 1C, F0, 1C as 1-cycle strobes -> FIFO holds {0,0,1C},{1,0,1C}; event_count=2; keys_held=0.
2. Bytes E0 75, then after 3 idle cycles E0 F0 75 -> events 175 then 375; keys_held[0]=1 one cycle after the first 75, and 0 one cycle after the second 75.
3. SUPPRESS_REPEAT=1: E0 6B sent three times, then E0 F0 6B -> exactly two events (16B, 36B); keys_held[2] goes 1 then 0.
4. DEPTH=8: nine untracked makes with no rd_en -> event_count=8, overflow=1, head=first code. Next cycle push+pop together -> count stays 8, overflow stays 1. clear_overflow -> 0.
5. ps2_key_pressed held high 5 cycles with data 1C -> exactly one event. rd_en while empty -> event_count stays 0, no state change.
6. Bytes E0, F0, then reset asserted, then 74 -> single event {0,0,74}; keys_held=0.

Source files
------------

// File: rtl/ps2_key_event_fifo.sv
// PS/2 scan-byte decoder (E0/F0 prefixes) feeding a show-ahead event FIFO plus a held-key bitmap.
// Latency: final byte to event_valid is one cycle; no backpressure, a full FIFO drops the event and sets overflow.
module ps2_key_event_fifo #(
  parameter int                     DEPTH           = 8,
  parameter int                     ADDR_W          = 3,
  parameter int                     NUM_KEYS        = 4,
  parameter logic [NUM_KEYS*9-1:0]  KEY_CODES       = {9'h175, 9'h172, 9'h16B, 9'h174},
  parameter bit                     SUPPRESS_REPEAT = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ps2_key_pressed,
  input  logic [7:0]          ps2_key_data,
  input  logic                rd_en,
  output logic [9:0]          event_data,
  output logic                event_valid,
  output logic [ADDR_W:0]     event_count,
  output logic                overflow,
  input  logic                clear_overflow,
  output logic [NUM_KEYS-1:0] keys_held
);

  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic                press_q;
  logic [ADDR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [9:0]          mem_q [DEPTH];

  logic                accept, emit, brk_w, ext_w;
  logic [NUM_KEYS-1:0] hit;
  logic                suppress, push_req, pop, push, drop, full;

  assign accept = ps2_key_pressed & ~press_q;

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    brk_w   = 1'b0;
    ext_w   = 1'b0;
    if (accept) begin
      if (ps2_key_data == 8'h00 || ps2_key_data == 8'hFF) begin
        state_d = S_IDLE;
      end else if (ps2_key_data == 8'hE0) begin
        state_d = S_E0;
      end else if (ps2_key_data == 8'hF0) begin
        // A break prefix keeps any pending extended prefix.
        state_d = (state_q == S_E0 || state_q == S_E0F0) ? S_E0F0 : S_F0;
      end else begin
        emit    = 1'b1;
        brk_w   = (state_q == S_F0) || (state_q == S_E0F0);
        ext_w   = (state_q == S_E0) || (state_q == S_E0F0);
        state_d = S_IDLE;
      end
    end
  end

  always_comb begin
    hit    = '0;
    held_d = held_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hit[i] = emit && ({ext_w, ps2_key_data} == KEY_CODES[(NUM_KEYS-1-i)*9 +: 9]);
      if (hit[i]) held_d[i] = ~brk_w;
    end
  end

  assign suppress = SUPPRESS_REPEAT && !brk_w && (|(hit & held_q));
  assign push_req = emit && !suppress;
  assign full     = (count_q == FULL_CNT);
  assign pop      = rd_en && (count_q != '0);
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    ovf_d = ovf_q;
    if (drop)                ovf_d = 1'b1;
    else if (clear_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      press_q  <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      held_q   <= '0;
    end else begin
      state_q  <= state_d;
      press_q  <= ps2_key_pressed;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      held_q   <= held_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) mem_q[wr_ptr_q] <= {brk_w, ext_w, ps2_key_data};
  end

  assign event_data  = mem_q[rd_ptr_q];
  assign event_valid = (count_q != '0);
  assign event_count = count_q;
  assign overflow    = ovf_q;
  assign keys_held   = held_q;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Directed plus randomized bench for ps2_key_event_fifo against a prefix-flag / queue reference model.
module tb_ps2_key_event_fifo;
  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_key_pressed;
  logic [7:0] ps2_key_data;
  logic       rd_en;
  logic       clear_overflow;
  logic [9:0] event_data;
  logic       event_valid;
  logic [3:0] event_count;
  logic       overflow;
  logic [3:0] keys_held;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending prefix flags, an event queue, overflow and held bits.
  logic [9:0] mq[$];
  bit         m_ovf, m_prev, m_ext, m_brk;
  bit [3:0]   m_held;
  logic [8:0] tk [4] = '{9'h175, 9'h172, 9'h16B, 9'h174};

  ps2_key_event_fifo dut (
    .clock(clock), .reset(reset), .ps2_key_pressed(ps2_key_pressed),
    .ps2_key_data(ps2_key_data), .rd_en(rd_en), .event_data(event_data),
    .event_valid(event_valid), .event_count(event_count), .overflow(overflow),
    .clear_overflow(clear_overflow), .keys_held(keys_held)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/valid"}, {31'd0, event_valid}, {31'd0, mq.size() > 0});
    check({tag, "/count"}, {28'd0, event_count}, mq.size());
    check({tag, "/ovf"},   {31'd0, overflow}, {31'd0, m_ovf});
    check({tag, "/held"},  {28'd0, keys_held}, {28'd0, m_held});
    if (mq.size() > 0) check({tag, "/head"}, {22'd0, event_data}, {22'd0, mq[0]});
  endtask

  task automatic model_cycle(input bit p, input logic [7:0] d, input bit rd, input bit clr);
    bit         pop, full, want, drop;
    logic [9:0] ev;
    pop  = rd && mq.size() > 0;
    full = (mq.size() == DEPTH);
    want = 1'b0;
    drop = 1'b0;
    ev   = '0;
    if (p && !m_prev) begin
      if (d == 8'h00 || d == 8'hFF) begin
        m_ext = 0; m_brk = 0;
      end else if (d == 8'hE0) begin
        m_ext = 1; m_brk = 0;
      end else if (d == 8'hF0) begin
        m_brk = 1;
      end else begin
        ev   = {m_brk, m_ext, d};
        want = 1'b1;
        for (int k = 0; k < 4; k++) begin
          if ({m_ext, d} == tk[k]) begin
            if (!m_brk && m_held[k]) want = 1'b0;
            m_held[k] = !m_brk;
          end
        end
        m_ext = 0; m_brk = 0;
      end
    end
    m_prev = p;
    if (pop) void'(mq.pop_front());
    if (want) begin
      if (!full || pop) mq.push_back(ev);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  // Called at a negedge; drives one cycle, then checks at the following negedge.
  task automatic step(input bit p, input logic [7:0] d, input bit rd, input bit clr, input string tag);
    ps2_key_pressed = p;
    ps2_key_data    = d;
    rd_en           = rd;
    clear_overflow  = clr;
    model_cycle(p, d, rd, clr);
    @(posedge clock);
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic send(input logic [7:0] d, input bit rd, input string tag);
    step(1'b1, d, rd, 1'b0, tag);
    step(1'b0, d, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    ps2_key_pressed = 1'b0;
    rd_en = 1'b0;
    clear_overflow = 1'b0;
    mq.delete();
    m_ovf = 0; m_prev = 0; m_ext = 0; m_brk = 0; m_held = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_all(tag);
  endtask

  task automatic drain(input string tag);
    for (int g = 0; g < 2 * DEPTH && mq.size() > 0; g++) step(1'b0, 8'h00, 1'b1, 1'b0, tag);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] trk [4];
    int len, gap;
    trk[0] = 8'h75; trk[1] = 8'h72; trk[2] = 8'h6B; trk[3] = 8'h74;
    reset = 1'b1; ps2_key_pressed = 0; ps2_key_data = 0; rd_en = 0; clear_overflow = 0;
    @(negedge clock);
    do_reset("reset");
    check("reset_count", {28'd0, event_count}, 32'd0);

    // 1: make/break of an untracked key
    send(8'h1C, 0, "t1"); send(8'hF0, 0, "t1"); send(8'h1C, 0, "t1");
    check("t1_count", {28'd0, event_count}, 32'd2);
    check("t1_head", {22'd0, event_data}, 32'h01C);
    drain("t1_drain");

    // 2: extended tracked key press and release
    send(8'hE0, 0, "t2"); step(1, 8'h75, 0, 0, "t2");
    check("t2_held_make", {31'd0, keys_held[0]}, 32'd1);
    step(0, 8'h75, 0, 0, "t2");
    repeat (3) step(0, 8'h00, 0, 0, "t2_idle");
    send(8'hE0, 0, "t2"); send(8'hF0, 0, "t2"); step(1, 8'h75, 0, 0, "t2");
    check("t2_held_brk", {31'd0, keys_held[0]}, 32'd0);
    step(0, 8'h75, 0, 0, "t2");
    check("t2_head", {22'd0, event_data}, 32'h175);
    drain("t2_drain");

    // 3: typematic repeats of a held key are suppressed
    repeat (3) begin send(8'hE0, 0, "t3"); send(8'h6B, 0, "t3"); end
    check("t3_held", {31'd0, keys_held[2]}, 32'd1);
    send(8'hE0, 0, "t3"); send(8'hF0, 0, "t3"); send(8'h6B, 0, "t3");
    check("t3_count", {28'd0, event_count}, 32'd2);
    drain("t3_drain");

    // 4: overflow, push+pop while full, clear
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 0, "t4");
    check("t4_count", {28'd0, event_count}, 32'd8);
    check("t4_ovf", {31'd0, overflow}, 32'd1);
    check("t4_head", {22'd0, event_data}, 32'h010);
    send(8'h20, 1, "t4_pushpop");
    check("t4_pp_count", {28'd0, event_count}, 32'd8);
    step(0, 8'h00, 0, 1, "t4_clr");
    check("t4_clr_ovf", {31'd0, overflow}, 32'd0);
    drain("t4_drain");

    // 5: long strobe yields one byte; pop when empty is ignored
    repeat (5) step(1, 8'h1C, 0, 0, "t5");
    step(0, 8'h1C, 0, 0, "t5");
    check("t5_count", {28'd0, event_count}, 32'd1);
    drain("t5_drain");
    step(0, 8'h00, 1, 0, "t5_empty_pop");
    check("t5_empty", {28'd0, event_count}, 32'd0);

    // 6: reset discards a partial prefix
    send(8'hE0, 0, "t6"); send(8'hF0, 0, "t6");
    do_reset("t6_reset");
    send(8'h74, 0, "t6");
    check("t6_head", {22'd0, event_data}, 32'h074);
    check("t6_held", {28'd0, keys_held}, 32'd0);
    drain("t6_drain");

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        3, 4, 5: b = trk[$urandom_range(0, 3)];
        default: b = 8'($urandom);
      endcase
      len = $urandom_range(1, 3);
      gap = $urandom_range(1, 2);
      for (int c = 0; c < len; c++)
        step(1, b, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, "rnd");
      for (int c = 0; c < gap; c++)
        step(0, b, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, "rnd");
      if ($urandom_range(0, 99) == 0) do_reset("rnd_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
